// File: rtl/mult_div_unit.sv
// Iterative one-bit-per-cycle multiply (shift-add) / restoring divide engine producing a {Hi, Lo} pair.
// Optional signed support is compiled in when MULTDIV_SIGNED_EN is defined (op[1] then selects signed).
module mult_div_unit #(
  parameter int WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [1:0]           op,
  input  logic [WIDTH-1:0]     SrcA,
  input  logic [WIDTH-1:0]     SrcB,
  output logic                 busy,
  output logic                 done,
  output logic [2*WIDTH-1:0]   MultAns
);

  // Handshake: start is accepted on an edge only in IDLE or DONE (dropped otherwise); busy is high from the
  // accepting edge through the FIX cycle; done is a one-cycle pulse with MultAns valid, and MultAns holds
  // until the next FIX.
  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX, S_DONE} state_t;

  state_t               state;
  logic [CW-1:0]        count;
  logic [2*WIDTH-1:0]   acc;
  logic [WIDTH-1:0]     opb;
  logic [WIDTH-1:0]     dividend;
  logic                 is_div;
  logic                 div_zero;
  logic                 neg_hi;
  logic                 neg_lo;
  logic                 signed_op;

`ifdef MULTDIV_SIGNED_EN
  assign signed_op = op[1];
`else
  logic unused_op_msb;
  assign unused_op_msb = op[1];
  assign signed_op     = 1'b0;
`endif

  logic [WIDTH-1:0] mag_a, mag_b;
  assign mag_a = (signed_op && SrcA[WIDTH-1]) ? -SrcA : SrcA;
  assign mag_b = (signed_op && SrcB[WIDTH-1]) ? -SrcB : SrcB;

  // Multiply step: conditional add into the upper half keeps its carry, then the whole register shifts right.
  logic [WIDTH:0]       add_sum;
  logic [2*WIDTH-1:0]   mult_next;
  assign add_sum   = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, opb};
  assign mult_next = acc[0] ? {add_sum, acc[WIDTH-1:1]} : {1'b0, acc[2*WIDTH-1:1]};

  // Divide step: the shifted remainder needs WIDTH+1 bits, plus one more bit to expose the borrow.
  logic [WIDTH+1:0]     trial;
  logic [2*WIDTH-1:0]   div_next;
  assign trial    = {1'b0, acc[2*WIDTH-1:WIDTH-1]} - {2'b0, opb};
  assign div_next = trial[WIDTH+1] ? {acc[2*WIDTH-2:0], 1'b0}
                                   : {trial[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};

  logic [2*WIDTH-1:0]   fix_ans;
  logic [WIDTH-1:0]     quot, rem;
  always_comb begin
    quot    = acc[WIDTH-1:0];
    rem     = acc[2*WIDTH-1:WIDTH];
    fix_ans = neg_hi ? -acc : acc;
    if (is_div) begin
      if (neg_hi) quot = -quot;
      if (neg_lo) rem  = -rem;
      fix_ans = div_zero ? {{WIDTH{1'b1}}, dividend} : {quot, rem};
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= S_IDLE;
      busy     <= 1'b0;
      done     <= 1'b0;
      MultAns  <= '0;
      count    <= '0;
      acc      <= '0;
      opb      <= '0;
      dividend <= '0;
      is_div   <= 1'b0;
      div_zero <= 1'b0;
      neg_hi   <= 1'b0;
      neg_lo   <= 1'b0;
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          done <= 1'b0;
          if (start) begin
            state    <= S_CALC;
            busy     <= 1'b1;
            count    <= CW'(WIDTH - 1);
            acc      <= {{WIDTH{1'b0}}, mag_a};
            opb      <= mag_b;
            dividend <= SrcA;
            is_div   <= op[0];
            div_zero <= (SrcB == '0);
            neg_hi   <= signed_op & (SrcA[WIDTH-1] ^ SrcB[WIDTH-1]);
            neg_lo   <= signed_op & SrcA[WIDTH-1];
          end else begin
            state <= S_IDLE;
          end
        end
        S_CALC: begin
          acc   <= is_div ? div_next : mult_next;
          count <= count - CW'(1);
          if (count == '0) state <= S_FIX;
        end
        S_FIX: begin
          MultAns <= fix_ans;
          done    <= 1'b1;
          busy    <= 1'b0;
          state   <= S_DONE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
